// File: rtl/traffic_light_ctrl_param.sv
// Two-road traffic light controller: min/max green with gap-out, all-red clearance,
// latched pedestrian service during B green, and a flashing-yellow maintenance mode.
module traffic_light_ctrl_param #(
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 10,
  parameter int YELLOW     = 2,
  parameter int ALL_RED    = 1,
  parameter int FLASH_HALF = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic       Ra,
  output logic       Ya,
  output logic       Ga,
  output logic       Rb,
  output logic       Yb,
  output logic       Gb,
  output logic       walk,
  output logic       ped_pend,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    G_A   = 3'd0,
    Y_A   = 3'd1,
    AR_B  = 3'd2,
    G_B   = 3'd3,
    Y_B   = 3'd4,
    AR_A  = 3'd5,
    FLASH = 3'd6
  } state_e;

  // Exit thresholds expressed as timer values seen on the final tick of a phase.
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_T    = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] FLASH_T = CNT_W'(FLASH_HALF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             ped_pend_q, ped_pend_d;
  logic             walk_q, walk_d;
  logic             flash_q, flash_d;
  logic             flash_toggle;
  logic             demand_b;
  logic             enter_gb;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    state_d      = state_q;
    flash_d      = flash_q;
    flash_toggle = 1'b0;
    demand_b     = Sb | ped_pend_q;

    if (flash_mode) begin
      if (state_q != FLASH) begin
        state_d = FLASH;
        flash_d = 1'b1;
      end else if (tick && (timer_q == FLASH_T)) begin
        flash_d      = ~flash_q;
        flash_toggle = 1'b1;
      end
    end else begin
      case (state_q)
        G_A:   if (tick && (((timer_q >= MIN_T) && ((demand_b && !Sa) || ped_pend_q)) ||
                            ((timer_q >= MAX_T) && demand_b)))
                 state_d = Y_A;
        Y_A:   if (tick && (timer_q == YEL_T)) state_d = AR_B;
        AR_B:  if (tick && (timer_q == AR_T))  state_d = G_B;
        G_B:   if (tick && (((timer_q >= MIN_T) && (!Sb || Sa)) || (timer_q >= MAX_T)))
                 state_d = Y_B;
        Y_B:   if (tick && (timer_q == YEL_T)) state_d = AR_A;
        AR_A:  if (tick && (timer_q == AR_T))  state_d = G_A;
        default: state_d = AR_A;  // FLASH exit and the unused encoding both clear through AR_A
      endcase
    end

    if ((state_d != state_q) || flash_toggle) begin
      timer_d = '0;
    end else if (tick && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end

    // A request arriving on the G_B entry clock is served by that green, not latched.
    enter_gb   = (state_d == G_B) && (state_q != G_B);
    ped_pend_d = enter_gb ? 1'b0 : (ped_pend_q | ped_req);
    if (state_d != G_B) begin
      walk_d = 1'b0;
    end else if (enter_gb) begin
      walk_d = ped_pend_q | ped_req;
    end else begin
      walk_d = walk_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= G_A;
      timer_q    <= '0;
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
      flash_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      timer_q    <= timer_d;
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
      flash_q    <= flash_d;
    end
  end

  always_comb begin
    {Ra, Ya, Ga, Rb, Yb, Gb} = 6'b000000;
    case (state_q)
      G_A:         {Ga, Rb} = 2'b11;
      Y_A:         {Ya, Rb} = 2'b11;
      AR_B, AR_A:  {Ra, Rb} = 2'b11;
      G_B:         {Ra, Gb} = 2'b11;
      Y_B:         {Ra, Yb} = 2'b11;
      FLASH:       {Ya, Yb} = {flash_q, flash_q};
      default:     {Ra, Rb} = 2'b11;  // show all-red while recovering from the unused encoding
    endcase
  end

  assign walk     = walk_q;
  assign ped_pend = ped_pend_q;
  assign phase    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_param.sv
// Self-checking bench for traffic_light_ctrl_param: directed timelines with literal
// expectations, then randomized stimulus compared every cycle against a behavioural model.
module tb_traffic_light_ctrl_param;

  localparam int CNT_W      = 8;
  localparam int MIN_GREEN  = 4;
  localparam int MAX_GREEN  = 10;
  localparam int YELLOW     = 2;
  localparam int ALL_RED    = 1;
  localparam int FLASH_HALF = 2;

  // Lamp table per phase, bits {Ra,Ya,Ga,Rb,Yb,Gb}; FLASH is handled separately.
  localparam logic [5:0] LAMP_TAB [6] = '{6'b001100, 6'b010100, 6'b100100,
                                          6'b100001, 6'b100010, 6'b100100};

  logic clk = 1'b0, reset_n = 1'b1, tick = 1'b0, Sa = 1'b0, Sb = 1'b0;
  logic ped_req = 1'b0, flash_mode = 1'b0;
  logic Ra, Ya, Ga, Rb, Yb, Gb, walk, ped_pend;
  logic [2:0] phase;
  bit clk_run = 1'b1;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: phase number, ticks counted in phase, pedestrian and flash flags.
  int m_ph = 0, m_t = 0;
  bit m_pend = 1'b0, m_walk = 1'b0, m_fl = 1'b0;

  traffic_light_ctrl_param #(
    .CNT_W(CNT_W), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW(YELLOW), .ALL_RED(ALL_RED), .FLASH_HALF(FLASH_HALF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .Sa(Sa), .Sb(Sb),
    .ped_req(ped_req), .flash_mode(flash_mode),
    .Ra(Ra), .Ya(Ya), .Ga(Ga), .Rb(Rb), .Yb(Yb), .Gb(Gb),
    .walk(walk), .ped_pend(ped_pend), .phase(phase)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int fixed_len(input int ph);
    case (ph)
      1, 4:    return YELLOW;
      2, 5:    return ALL_RED;
      default: return 0;
    endcase
  endfunction

  // Phase reached at the end of a tick, given t ticks already counted in the current phase.
  function automatic int after_tick(input int ph, input int t, input bit sa, input bit sb,
                                    input bit pend);
    bit db;
    db = sb | pend;
    case (ph)
      0: return ((t >= MIN_GREEN-1 && ((db && !sa) || pend)) || (t >= MAX_GREEN-1 && db)) ? 1 : 0;
      3: return ((t >= MIN_GREEN-1 && (!sb || sa)) || t >= MAX_GREEN-1) ? 4 : 3;
      default: return (t + 1 >= fixed_len(ph)) ? (ph + 1) % 6 : ph;
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_ph = 0; m_t = 0; m_pend = 0; m_walk = 0; m_fl = 0;
    end else begin
      int nph;
      bit toggle, enter_gb;
      nph = m_ph;
      toggle = 0;
      if (flash_mode) begin
        if (m_ph != 6) begin
          nph = 6;
          m_fl = 1;
        end else if (tick && m_t == FLASH_HALF-1) begin
          toggle = 1;
        end
      end else if (m_ph == 6) begin
        nph = 5;
      end else if (tick) begin
        nph = after_tick(m_ph, m_t, Sa, Sb, m_pend);
      end
      if (toggle) m_fl = !m_fl;
      enter_gb = (nph == 3) && (m_ph != 3);
      m_walk = (nph == 3) ? (enter_gb ? (m_pend | ped_req) : m_walk) : 1'b0;
      m_pend = enter_gb ? 1'b0 : (m_pend | ped_req);
      if (nph != m_ph || toggle) m_t = 0;
      else if (tick && m_t < 2**CNT_W - 1) m_t = m_t + 1;
      m_ph = nph;
    end
  end

  always @(negedge clk) begin
    logic [5:0] exp_lamps;
    exp_lamps = (m_ph == 6) ? {1'b0, m_fl, 1'b0, 1'b0, m_fl, 1'b0} : LAMP_TAB[m_ph];
    check("cmp_phase", 32'(phase), 32'(m_ph));
    check("cmp_lamps", 32'({Ra, Ya, Ga, Rb, Yb, Gb}), 32'(exp_lamps));
    check("cmp_walk", 32'(walk), 32'(m_walk));
    check("cmp_pend", 32'(ped_pend), 32'(m_pend));
  end

  task automatic end_cycle();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench inside cycle 0: reset released, no active edge seen yet.
  task automatic reset_start(input bit sa, input bit sb);
    @(posedge clk); #2;
    reset_n = 1'b0; Sa = sa; Sb = sb; tick = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  // Called just after a rising edge: freezes the clock high, resets, checks, then restarts.
  task automatic async_reset_check(input string name);
    ped_req = 1'b0;
    clk_run = 1'b0;
    #12;
    reset_n = 1'b0;
    #1;
    check({name, "_phase"}, 32'(phase), 32'd0);
    check({name, "_lamps"}, 32'({Ra, Ya, Ga, Rb, Yb, Gb}), 32'b001100);
    check({name, "_walk"}, 32'(walk), 32'd0);
    check({name, "_pend"}, 32'(ped_pend), 32'd0);
    clk_run = 1'b1;
    @(posedge clk); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    int gap_ref [21] = '{0,0,0,0,1,1,2,3,3,3,3,3,3,3,3,3,3,4,4,5,0};
    int max_ref [18] = '{0,0,0,0,0,0,0,0,0,0,1,1,2,3,3,3,3,4};
    int ped_ref [15] = '{0,0,0,0,1,1,2,3,3,3,3,4,4,5,0};
    int pend_ref[15] = '{0,0,0,1,1,1,1,0,0,0,0,0,0,0,0};
    int ya_ref  [5]  = '{0,0,0,0,1};

    #1 reset_n = 1'b0;

    // Rest on A with no B demand.
    reset_start(1'b1, 1'b0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      check("rest_phase", 32'(phase), 32'd0);
      check("rest_GaRb", 32'({Ga, Rb}), 32'b11);
      end_cycle();
    end

    // Gap-out timeline, first with tick every clk, then every third clk.
    for (int div = 1; div <= 3; div += 2) begin
      reset_start(1'b0, 1'b1);
      for (int k = 0; k < 21 * div; k++) begin
        tick = (div == 1) || (k % 3 == 2);
        @(negedge clk);
        check(div == 1 ? "gapout_phase" : "gapout3_phase", 32'(phase), 32'(gap_ref[k / div]));
        end_cycle();
      end
    end

    // Max-out on A with demand on both roads.
    reset_start(1'b1, 1'b1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check("maxout_phase", 32'(phase), 32'(max_ref[k]));
      end_cycle();
    end

    // Pedestrian request latched and served during B green.
    reset_start(1'b1, 1'b0);
    for (int k = 0; k < 15; k++) begin
      ped_req = (k == 2);
      @(negedge clk);
      check("ped_phase", 32'(phase), 32'(ped_ref[k]));
      check("ped_pend", 32'(ped_pend), 32'(pend_ref[k]));
      check("ped_walk", 32'(walk), (k >= 7 && k <= 10) ? 32'd1 : 32'd0);
      end_cycle();
    end
    ped_req = 1'b0;

    // Request on the G_B entry clock, then flash mode from the second G_B cycle.
    reset_start(1'b0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      ped_req    = (k == 6) || (k == 10);
      flash_mode = (k >= 8 && k <= 16);
      @(negedge clk);
      if (k == 7 || k == 8) begin
        check("coinc_phase", 32'(phase), 32'd3);
        check("coinc_walk", 32'(walk), 32'd1);
        check("coinc_pend", 32'(ped_pend), 32'd0);
      end
      if (k >= 9 && k <= 17) begin
        check("flash_phase", 32'(phase), 32'd6);
        check("flash_Ya", 32'(Ya), ((k - 9) / 2) % 2 == 0 ? 32'd1 : 32'd0);
        check("flash_Yb", 32'(Yb), ((k - 9) / 2) % 2 == 0 ? 32'd1 : 32'd0);
        check("flash_others", 32'({Ra, Ga, Rb, Gb, walk}), 32'd0);
      end
      if (k >= 11) check("flash_pend_kept", 32'(ped_pend), 32'd1);
      if (k == 18) check("flash_exit_phase", 32'(phase), 32'd5);
      if (k == 19) check("flash_resume_phase", 32'(phase), 32'd0);
      end_cycle();
    end
    ped_req = 1'b0;
    flash_mode = 1'b0;

    // Asynchronous reset during Y_A with a pending request, then timer restarts at 0.
    reset_start(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      ped_req = (k == 1);
      @(negedge clk);
      check("rst_pre_phase", 32'(phase), 32'(ya_ref[k]));
      if (k >= 2) check("rst_pre_pend", 32'(ped_pend), 32'd1);
      end_cycle();
    end
    async_reset_check("rst_ya");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("rst_post_phase", 32'(phase), 32'(ya_ref[k]));
      end_cycle();
    end

    // Asynchronous reset during G_B with walk lit.
    reset_start(1'b0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      ped_req = (k == 1) || (k == 7);
      @(negedge clk);
      if (k >= 7) check("rstgb_walk", 32'(walk), 32'd1);
      if (k == 8) check("rstgb_pend", 32'(ped_pend), 32'd1);
      end_cycle();
    end
    async_reset_check("rst_gb");

    // Randomized traffic, pedestrians, flash episodes and occasional resets.
    reset_start(1'b0, 1'b0);
    for (int c = 0; c < 4000; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) Sa = !Sa;
      if ($urandom_range(0, 7) == 0) Sb = !Sb;
      ped_req = ($urandom_range(0, 19) == 0);
      if (flash_mode ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0))
        flash_mode = !flash_mode;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      end_cycle();
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
